// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-and-add N x N -> 2N multiplier with valid/ready handshakes.
// Optional macro SEQ_MULT_EARLY_TERM_EN: CALC stops once the remaining multiplier bits are all zero.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               signed_mode,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [2*WIDTH-1:0] mult_out,
  output logic               valid_out,
  input  logic               ready_in
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mcand, mplier;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [CW-1:0] cnt;
  logic sign, accept, drain, last;
  assign accept = valid_in && ready_out;
  assign drain = valid_out && ready_in;
  assign acc_nx = acc + (mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0);
`ifdef SEQ_MULT_EARLY_TERM_EN
  assign last = (mplier >> 1) == '0;
`else
  assign last = cnt == CW'(WIDTH - 1);
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state: accept -> CALC, final step -> DONE, output handshake -> IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = accept ? CALC : IDLE;
      CALC: state_nx = last ? DONE : CALC;
      DONE: state_nx = drain ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // datapath: latch magnitudes at accept, one shift-add step per CALC cycle, sign-fix on exit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      sign <= 1'b0;
      mult_out <= '0;
      valid_out <= 1'b0;
      ready_out <= 1'b1;
    end else if (accept) begin
      mcand <= (signed_mode && in_a[WIDTH-1]) ? -in_a : in_a;
      mplier <= (signed_mode && in_b[WIDTH-1]) ? -in_b : in_b;
      sign <= signed_mode & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
      acc <= '0;
      cnt <= '0;
      ready_out <= 1'b0;
    end else if (state == CALC) begin
      acc <= acc_nx;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
      if (last) begin
        mult_out <= sign ? -acc_nx : acc_nx;
        valid_out <= 1'b1;
      end
    end else if (drain) begin
      valid_out <= 1'b0;
      ready_out <= 1'b1;
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and random checks of seq_multiplier against an arithmetic reference model.
module tb_seq_multiplier;
  localparam int W = 8;
`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic signed_mode = 1'b0, valid_in = 1'b0, ready_in = 1'b1;
  logic ready_out, valid_out;
  logic [2*W-1:0] mult_out;
  int vectors = 0, miscompares = 0, n_push = 0, n_pop = 0;
  bit go = 1'b0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .signed_mode(signed_mode),
    .valid_in(valid_in), .ready_out(ready_out), .mult_out(mult_out),
    .valid_out(valid_out), .ready_in(ready_in)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // product by plain arithmetic: extend each operand to 2W bits, multiply modulo 2^(2W)
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    logic [2*W-1:0] sa, sb;
    sa = {{W{sm & a[W-1]}}, a};
    sb = {{W{sm & b[W-1]}}, b};
    return sa * sb;
  endfunction

  // latency in cycles from accept to valid_out
  function automatic int klat(input logic [W-1:0] b, input logic sm);
    logic [W-1:0] m;
    int k;
    if (!ET) return W;
    m = (sm && b[W-1]) ? -b : b;
    k = 1;
    for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
    return k;
  endfunction

  // cycle-level reference: idle until accept, busy for klat cycles, then hold result until handshake
  logic m_ready = 1'b1, m_valid = 1'b0;
  logic [2*W-1:0] m_out = '0, m_prod = '0;
  int m_left = 0;
  logic [2*W-1:0] sbq[$];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_out <= '0;
      m_left <= 0;
      sbq.delete();
    end else if (m_ready && valid_in) begin
      m_ready <= 1'b0;
      m_left <= klat(in_b, signed_mode);
      m_prod <= ref_prod(in_a, in_b, signed_mode);
      sbq.push_back(ref_prod(in_a, in_b, signed_mode));
      n_push++;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_out <= m_prod;
      end
    end else if (m_valid && ready_in) begin
      m_valid <= 1'b0;
      m_ready <= 1'b1;
    end

  // every-cycle compare of all outputs against the model
  always @(negedge clk)
    if (go) begin
      check("cyc ready_out", ready_out, m_ready);
      check("cyc valid_out", valid_out, m_valid);
      check("cyc mult_out", mult_out, m_out);
    end

  // in-order scoreboard on every output handshake
  always @(posedge clk)
    if (go && rst_n && valid_out && ready_in) begin
      n_pop++;
      if (sbq.size() == 0) check("sb unexpected result", mult_out, '1);
      else check("sb in-order result", mult_out, sbq.pop_front());
    end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm, input bit rr);
    int t = 0;
    @(negedge clk);
    while (!ready_out && t < 100) begin
      if (rr) ready_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      t++;
    end
    if (!ready_out) check("launch timeout", 0, 1);
    in_a = a;
    in_b = b;
    signed_mode = sm;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    signed_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid_out && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                    input logic [2*W-1:0] exp, input int exp_lat);
    int lat;
    launch(a, b, sm, 1'b0);
    wait_valid(lat);
    check({name, " product"}, mult_out, exp);
    check({name, " latency"}, lat, exp_lat);
    @(negedge clk);
    check({name, " ready after"}, ready_out, 1);
  endtask

  initial begin
    int lat, t;
    repeat (2) @(negedge clk);
    check("reset ready_out", ready_out, 1);
    check("reset valid_out", valid_out, 0);
    check("reset mult_out", mult_out, 0);
    #2 rst_n = 1'b1;
    go = 1'b1;
    op("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 8);
    op("s-128x-128", 8'h80, 8'h80, 1'b1, 16'h4000, 8);
    op("s-3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, ET ? 3 : 8);
    op("u80x02", 8'h80, 8'h02, 1'b0, 16'h0100, ET ? 2 : 8);
    op("u7x3", 8'h07, 8'h03, 1'b0, 16'd21, ET ? 2 : 8);
    op("u55x0", 8'h55, 8'h00, 1'b0, 16'h0000, ET ? 1 : 8);
    op("s0x0", 8'h00, 8'h00, 1'b1, 16'h0000, ET ? 1 : 8);
    op("u1x80", 8'h01, 8'h80, 1'b0, 16'h0080, 8);
    op("s7x-1", 8'h07, 8'hFF, 1'b1, 16'hFFF9, ET ? 1 : 8);
    // backpressure with an ignored valid_in pulse during the stall
    ready_in = 1'b0;
    launch(8'd9, 8'd9, 1'b0, 1'b0);
    wait_valid(lat);
    check("stall product", mult_out, 16'd81);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_a = 8'd2;
        in_b = 8'd2;
        valid_in = 1'b1;
      end else valid_in = 1'b0;
      @(negedge clk);
      check("stall valid_out", valid_out, 1);
      check("stall mult_out", mult_out, 16'd81);
      check("stall ready_out", ready_out, 0);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(negedge clk);
    check("stall release valid_out", valid_out, 0);
    check("stall release ready_out", ready_out, 1);
    op("after stall u3x4", 8'd3, 8'd4, 1'b0, 16'd12, ET ? 3 : 8);
    // reset in the middle of CALC
    launch(8'hAB, 8'hCD, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset ready_out", ready_out, 1);
    check("midreset valid_out", valid_out, 0);
    check("midreset mult_out", mult_out, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    op("post reset u7x6", 8'd7, 8'd6, 1'b0, 16'd42, ET ? 3 : 8);
    // random stream with random backpressure
    n_push = 0;
    n_pop = 0;
    for (int i = 0; i < 10; i++)
      launch(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    ready_in = 1'b1;
    t = 0;
    while ((sbq.size() != 0 || !ready_out) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("stream drained", sbq.size(), 0);
    check("stream results count", n_pop, 10);
    check("stream accepts count", n_push, 10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential integer multiplier with a radix-2 shift-and-add datapath.
- Computes an N×N → 2N product, signed or unsigned, selected per operation.
- Valid/ready handshake on both the input and the result side, so downstream can apply backpressure.
- Sits between an operand producer and a result consumer in the arithmetic datapath. It is the general-width, handshaked successor to the team's 4-bit repeated-addition multiplier.

## Interface
Parameters:
- WIDTH, 8, operand width N in bits; WIDTH ≥ 2; result is 2*WIDTH bits.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_a  in  WIDTH  multiplicand; sampled only on the accept edge.
- in_b  in  WIDTH  multiplier; sampled only on the accept edge.
- signed_mode  in  1  1 = operands and result are two's complement; sampled on the accept edge.
- valid_in  in  1  operand pair valid.
- ready_out  out  1  block can accept an operand pair (registered).
- mult_out  out  2*WIDTH  product.
- valid_out  out  1  mult_out holds a finished product (registered).
- ready_in  in  1  downstream accepts the result.

## Operation
- States: IDLE, CALC, DONE. Reset values: IDLE, ready_out=1, valid_out=0, mult_out=0, all internal registers 0.
- IDLE: ready_out=1. Accept occurs on the edge where valid_in && ready_out.
  - At accept: latch magnitudes |a| and |b| (raw values if signed_mode=0) into WIDTH-bit unsigned registers.
  - At accept: latch sign = signed_mode & (a[MSB] ^ b[MSB]), clear the 2*WIDTH accumulator, clear the step counter.
  - At accept: ready_out←0, go to CALC.
- CALC, one bit per edge:
  - If mplier[0]=1, acc += mcand (mcand zero-extended and left-shifted by the step count).
  - Then mplier >>= 1 and the counter increments.
- CALC exit: after the final step, mult_out ← sign ? −acc_final : acc_final (2*WIDTH-bit two's complement), valid_out←1, go to DONE.
- DONE:
  - mult_out and valid_out are held stable.
  - On the edge where valid_out && ready_in: valid_out←0, ready_out←1, go to IDLE.
  - mult_out keeps its last value until the next DONE entry.
- Width rules:
  - The magnitude of the most negative value (e.g. −128 for WIDTH=8) fits in WIDTH unsigned bits.
  - The product magnitude is ≤ 2^(2W−2), so no overflow is possible.
  - Unsigned 2^W−1 squared fits exactly in 2W bits.
- valid_in while ready_out=0 is ignored. Operand changes after the accept edge have no effect.
- Reset asserted in any state aborts the operation immediately and restores the reset values. The partial result is discarded.

## Timing
- Accept edge E0. CALC steps occur on E1..Ek. valid_out is visible after Ek.
- Input-to-output latency is k cycles. k = WIDTH when the early-termination macro is absent.
- Minimum initiation interval is k+2 cycles: accept, k CALC cycles, one DONE cycle with ready_in=1, one IDLE cycle.
- ready_out rises on the same edge that completes the output handshake. The next accept can happen one cycle later.
- ready_in held low stalls DONE indefinitely with no data loss.

## Configuration
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined: CALC exits on the step where the shifted multiplier becomes 0.
  - k = (index of highest set bit of |b|) + 1.
  - k = 1 when |b| = 0.
- Undefined: CALC always runs exactly WIDTH steps, giving data-independent latency.
- Both variants produce identical results. The only difference is latency.

## Test plan
- Unsigned 255×255, WIDTH=8, macro undefined, ready_in=1 → mult_out=0xFE01, valid_out 8 cycles after accept, ready_out=1 on the following cycle.
- Signed −128×−128 → 0x4000. Signed −3×5 → 0xFFF1. Unsigned 0x80×0x02 (signed_mode=0) → 0x0100.
- Backpressure: hold ready_in=0 for 5 cycles after valid_out. valid_out and mult_out stay stable and ready_out stays 0. A valid_in pulse with new operands during the stall is ignored; the next product is from the next accepted pair only.
- Early termination (macro defined): b=3 → k=2. b=0 or a×0 → result 0 with k=1. b=0x80 → k=8. With the macro undefined, all cases give k=8.
- Assert rst_n=0 for one cycle mid-CALC. Outputs return to ready_out=1, valid_out=0, mult_out=0. A new operation 7×6 then yields 42 with normal latency.
- Back-to-back: stream 10 random signed and unsigned pairs with random ready_in. Every result matches the reference model in order, with no drops or duplicates.
